// File: rtl/pipe_adder_pkg.sv
// Shared configuration helpers for the segmented pipelined adder.
// Stage count derivation and the legality rule for WIDTH/SEG_W pairs.
package pipe_adder_pkg;

   function automatic int nseg(input int width, input int segW);
      return (segW >= 1) ? width / segW : 1;
   endfunction

   function automatic bit cfgValid(input int width, input int segW);
      return (segW >= 1) && (width >= segW) && ((width % segW) == 0);
   endfunction

endpackage

// File: rtl/rca_seg.sv
// One combinational ripple-carry segment; also exposes the carry into its
// top bit so the final segment can derive signed overflow.
module rca_seg #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o,
   output logic         cMsbIn_o
);

   logic [W:0] carry;

   always_comb begin
      carry    = '0;
      sum_o    = '0;
      carry[0] = cin_i;
      for (int i = 0; i < W; i++) begin
         sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
         carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
      end
   end

   assign cout_o   = carry[W];
   assign cMsbIn_o = carry[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one register stage per SEG_W-bit carry segment,
// with a single global advance enable driven by the output handshake.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSEG = nseg(WIDTH, SEG_W);

   if (!cfgValid(WIDTH, SEG_W)) begin : gBadCfg
      $error("pipe_adder: WIDTH must be a positive multiple of SEG_W");
   end

   // Each stage carries the finished low sum bits plus the untouched high operand bits.
   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             carry;
      logic             ovf;
   } stage_t;

   stage_t entry;
   stage_t stage_q [NSEG];
   logic   en;

   // Subtraction becomes a + ~b + ~cin, so the inversion happens once at entry.
   always_comb begin
      entry       = '0;
      entry.valid = in_valid;
      entry.a     = a;
      entry.b     = sub ? ~b : b;
      entry.carry = sub ? ~cin : cin;
   end

   for (genvar k = 0; k < NSEG; k++) begin : gStage
      stage_t           src;
      stage_t           stage_d;
      logic [SEG_W-1:0] segSum;
      logic             segCout;
      logic             segCMsb;

      if (k == 0) begin : gFirst
         assign src = entry;
      end else begin : gNext
         assign src = stage_q[k-1];
      end

      rca_seg #(.W(SEG_W)) uSeg (
         .a_i      (src.a[k*SEG_W +: SEG_W]),
         .b_i      (src.b[k*SEG_W +: SEG_W]),
         .cin_i    (src.carry),
         .sum_o    (segSum),
         .cout_o   (segCout),
         .cMsbIn_o (segCMsb)
      );

      always_comb begin
         stage_d                         = src;
         stage_d.sum[k*SEG_W +: SEG_W]   = segSum;
         stage_d.carry                   = segCout;
         stage_d.ovf                     = segCout ^ segCMsb;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stage_q[k] <= '0;
         end else if (en) begin
            stage_q[k] <= stage_d;
         end
      end
   end

   assign out_valid = stage_q[NSEG-1].valid;
   assign sum       = stage_q[NSEG-1].sum;
   assign cout      = stage_q[NSEG-1].carry;
   assign ovf       = stage_q[NSEG-1].ovf;
   assign en        = !out_valid || out_ready;
   assign in_ready  = en;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench: 8-bit/4-bit-segment pipe checked against an arithmetic
// scoreboard, plus a single-stage 4-bit instance for the legacy vectors.
module tb_pipe_adder;

   logic clk;
   logic rst_n;

   logic       inValid8, inReady8, outValid8, outReady8;
   logic [7:0] a8, b8, sum8;
   logic       cin8, sub8, cout8, ovf8;

   logic       inValid4, inReady4, outValid4, outReady4;
   logic [3:0] a4, b4, sum4;
   logic       cin4, sub4, cout4, ovf4;

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      int         cyc;
      bit         strict;
   } exp_t;

   exp_t q[$];
   int   checks     = 0;
   int   errors     = 0;
   int   cycleCount = 0;
   int   emitCount  = 0;
   bit   strictLat  = 1'b0;
   bit   lastAccept = 1'b0;

   pipe_adder #(.WIDTH(8), .SEG_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(inValid8), .in_ready(inReady8),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8),
      .out_valid(outValid8), .out_ready(outReady8),
      .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   pipe_adder #(.WIDTH(4), .SEG_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(inValid4), .in_ready(inReady4),
      .a(a4), .b(b4), .cin(cin4), .sub(sub4),
      .out_valid(outValid4), .out_ready(outReady4),
      .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference result from plain integer arithmetic on the operand values.
   function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s);
      exp_t e;
      int   ua, ub, sa, sb, ci, r, sr;
      ua = int'(av);
      ub = int'(bv);
      sa = int'($signed(av));
      sb = int'($signed(bv));
      ci = c ? 1 : 0;
      if (!s) begin
         r      = ua + ub + ci;
         sr     = sa + sb + ci;
         e.cout = (r > 255);
      end else begin
         r      = ua - ub - ci;
         sr     = sa - sb - ci;
         e.cout = (r >= 0);
      end
      e.sum    = 8'(r);
      e.ovf    = (sr > 127) || (sr < -128);
      e.cyc    = 0;
      e.strict = 1'b0;
      return e;
   endfunction

   task automatic applyStimulus(input logic v, input logic [7:0] av, input logic [7:0] bv,
                                input logic c, input logic s, input logic r);
      exp_t e;
      @(negedge clk);
      inValid8  = v;
      a8        = av;
      b8        = bv;
      cin8      = c;
      sub8      = s;
      outReady8 = r;
      #1;
      cycleCount++;
      lastAccept = 1'b0;
      if (outValid8 && !outReady8) begin
         checkOutput("stallInReady", 32'(inReady8), 32'd0);
         if (q.size() > 0) begin
            checkOutput("stallSum", 32'(sum8), 32'(q[0].sum));
            checkOutput("stallCout", 32'(cout8), 32'(q[0].cout));
            checkOutput("stallOvf", 32'(ovf8), 32'(q[0].ovf));
         end
      end
      if (outValid8 && outReady8) begin
         emitCount++;
         if (q.size() == 0) begin
            checkOutput("unexpectedEmit", 32'(outValid8), 32'd0);
         end else begin
            e = q.pop_front();
            checkOutput("sum", 32'(sum8), 32'(e.sum));
            checkOutput("cout", 32'(cout8), 32'(e.cout));
            checkOutput("ovf", 32'(ovf8), 32'(e.ovf));
            if (e.strict) checkOutput("latency", 32'(cycleCount - e.cyc), 32'd2);
         end
      end
      if (inValid8 && inReady8) begin
         e        = model(av, bv, c, s);
         e.cyc    = cycleCount;
         e.strict = strictLat;
         q.push_back(e);
         lastAccept = 1'b1;
      end
   endtask

   task automatic drain();
      int guard = 0;
      while (q.size() > 0 && guard < 20) begin
         applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
         guard++;
      end
      checkOutput("drainEmpty", 32'(q.size()), 32'd0);
   endtask

   task automatic applyLegacy(input logic [3:0] av, input logic [3:0] bv, input logic c,
                              input logic [3:0] expSum, input logic expCout);
      @(negedge clk);
      inValid4 = 1'b1;
      a4       = av;
      b4       = bv;
      cin4     = c;
      #1;
      checkOutput("legacyInReady", 32'(inReady4), 32'd1);
      @(negedge clk);
      inValid4 = 1'b0;
      #1;
      checkOutput("legacyValid", 32'(outValid4), 32'd1);
      checkOutput("legacySum", 32'(sum4), 32'(expSum));
      checkOutput("legacyCout", 32'(cout4), 32'(expCout));
   endtask

   initial begin
      int i;
      int guard;
      int emitsBefore;

      rst_n     = 1'b0;
      inValid8  = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; outReady8 = 1'b1;
      inValid4  = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; outReady4 = 1'b1;
      #1;
      checkOutput("rstValid8", 32'(outValid8), 32'd0);
      checkOutput("rstSum8", 32'(sum8), 32'd0);
      checkOutput("rstCout8", 32'(cout8), 32'd0);
      checkOutput("rstOvf8", 32'(ovf8), 32'd0);
      checkOutput("rstInReady8", 32'(inReady8), 32'd1);
      checkOutput("rstValid4", 32'(outValid4), 32'd0);
      #21;
      rst_n = 1'b1;

      $display("[TB] directed add/sub vectors");
      strictLat = 1'b1;
      applyStimulus(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 1'b1);
      drain();

      $display("[TB] backpressure stream");
      strictLat = 1'b0;
      i     = 0;
      guard = 0;
      while (i < 6 && guard < 50) begin
         applyStimulus(1'b1, 8'(8'h10 + i), 8'h01, 1'b0, 1'b0, !(guard >= 3 && guard < 6));
         if (lastAccept) i++;
         guard++;
      end
      checkOutput("bpAccepted", 32'(i), 32'd6);
      drain();

      $display("[TB] reset with entries in flight");
      applyStimulus(1'b1, 8'h21, 8'h03, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h40, 8'h40, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      inValid8 = 1'b0;
      #1;
      checkOutput("preRstValid", 32'(outValid8), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midRstValid", 32'(outValid8), 32'd0);
      checkOutput("midRstSum", 32'(sum8), 32'd0);
      checkOutput("midRstCout", 32'(cout8), 32'd0);
      checkOutput("midRstOvf", 32'(ovf8), 32'd0);
      checkOutput("midRstInReady", 32'(inReady8), 32'd1);
      q.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      strictLat   = 1'b1;
      emitsBefore = emitCount;
      applyStimulus(1'b1, 8'h33, 8'h44, 1'b1, 1'b0, 1'b1);
      checkOutput("postRstInReady", 32'(inReady8), 32'd1);
      for (int k = 0; k < 5; k++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      checkOutput("postRstEmits", 32'(emitCount - emitsBefore), 32'd1);
      checkOutput("postRstIdle", 32'(outValid8), 32'd0);

      $display("[TB] randomized traffic");
      strictLat = 1'b0;
      for (int k = 0; k < 300; k++) begin
         applyStimulus($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom),
                       1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      end
      drain();

      $display("[TB] legacy 4-bit single-stage vectors");
      applyLegacy(4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0);
      applyLegacy(4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1);
      applyLegacy(4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0);
      applyLegacy(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
